// File: rtl/sobel_pkg.sv
// Shared types for the Sobel front end: pixel/column types, the 3-pixel column and the priming counter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sobel_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int LINE_W_DEF = 16;

    typedef logic [PIX_W_DEF-1:0]          pix_t;
    typedef logic [$clog2(LINE_W_DEF)-1:0] col_t;

    // One vertical column of the 3x3 window, oldest row on top.
    typedef struct packed {
        pix_t top;
        pix_t mid;
        pix_t bot;
    } win_col_t;

    // Priming counter: two lines must be stored before columns are complete.
    typedef enum logic [1:0] {
        ROW_PRIME0 = 2'd0,
        ROW_PRIME1 = 2'd1,
        ROW_LIVE   = 2'd2
    } row_e;

    // Advance the priming counter at end of line, saturating once live.
    function automatic row_e row_advance(input row_e r);
        row_e nxt;
        nxt = ROW_LIVE;
        if (r == ROW_PRIME0) begin
            nxt = ROW_PRIME1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_ram_block.sv
// Simple dual-read, single-write synchronous RAM; read data registered and held while rd_en is low.
// Latency: 1 cycle from read enable to data.
// Backpressure: none; caller gates rd_en/wr_en.
module sync_ram_block #(
    parameter int WIDTH_P = 16,
    parameter int DEPTH_P = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       rd_en_a_i,
    input  logic [$clog2(DEPTH_P)-1:0] rd_addr_a_i,
    output logic [WIDTH_P-1:0]         rd_dat_a_o,
    input  logic                       rd_en_b_i,
    input  logic [$clog2(DEPTH_P)-1:0] rd_addr_b_i,
    output logic [WIDTH_P-1:0]         rd_dat_b_o,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH_P)-1:0] wr_addr_i,
    input  logic [WIDTH_P-1:0]         wr_dat_i
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    // Storage array: no reset, contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_dat_i;
        end
    end

    // Port A read register: updates only on a read, otherwise holds the last word.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_dat_a_o <= '0;
        end else if (rd_en_a_i) begin
            rd_dat_a_o <= mem[rd_addr_a_i];
        end
    end

    // Port B read register, same holding behaviour as port A.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_dat_b_o <= '0;
        end else if (rd_en_b_i) begin
            rd_dat_b_o <= mem[rd_addr_b_i];
        end
    end

endmodule

// File: rtl/sobel_line_buffer.sv
// Turns a raster pixel stream into vertical {row n-2, row n-1, row n} columns for the Sobel window.
// Latency: 1 cycle from pixel accept to column valid (combinational from s1 + RAM output).
// Backpressure: valid/ready both sides; a stalled column holds s1 and blocks new pixels.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [PIX_W-1:0]          pix_i,
    input  logic                      sof_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [PIX_W-1:0]          top_o,
    output logic [PIX_W-1:0]          mid_o,
    output logic [PIX_W-1:0]          bot_o,
    output logic [$clog2(LINE_W)-1:0] col_o,
    output logic                      eol_o,
    output logic                      valid_o,
    input  logic                      ready_i
);

    localparam int            CW       = $clog2(LINE_W);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);

    // Raster position of the next pixel to be accepted.
    logic [CW-1:0] col_q;
    row_e          row_q;
    logic [CW-1:0] col_eff;
    row_e          row_eff;
    logic [CW-1:0] col_nxt;
    row_e          row_nxt;

    // s1: the pixel whose RAM word is being read / about to be written back.
    logic             v1_q;
    logic [PIX_W-1:0] pix1_q;
    logic [CW-1:0]    col1_q;
    row_e             row1_q;

    logic                 accept;
    logic                 emit;
    logic                 retire;
    logic [2*PIX_W-1:0]   ram_rd_dat;
    logic [2*PIX_W-1:0]   ram_wr_dat;
    logic [2*PIX_W-1:0]   ram_b_unused;

    assign accept  = valid_i & ready_o;
    assign emit    = v1_q & (row1_q == ROW_LIVE);
    assign retire  = v1_q & (~emit | ready_i);
    assign ready_o = ~v1_q | retire;

    // Shift lines up on write-back: old row n-1 becomes row n-2, current pixel becomes row n-1.
    assign ram_wr_dat = {ram_rd_dat[PIX_W-1:0], pix1_q};

    // sof re-anchors the incoming pixel to row 0 col 0; the next position follows from there.
    always_comb begin
        col_eff = sof_i ? '0 : col_q;
        row_eff = sof_i ? ROW_PRIME0 : row_q;
        col_nxt = col_eff + CW'(1);
        row_nxt = row_eff;
        if (col_eff == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row_advance(row_eff);
        end
    end

    // Raster counters advance once per accepted pixel.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q <= '0;
            row_q <= ROW_PRIME0;
        end else if (accept) begin
            col_q <= col_nxt;
            row_q <= row_nxt;
        end
    end

    // s1 register: loads on accept, empties when its pixel retires without a replacement.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1_q   <= 1'b0;
            pix1_q <= '0;
            col1_q <= '0;
            row1_q <= ROW_PRIME0;
        end else if (accept) begin
            v1_q   <= 1'b1;
            pix1_q <= pix_i;
            col1_q <= col_eff;
            row1_q <= row_eff;
        end else if (retire) begin
            v1_q   <= 1'b0;
        end
    end

    // Column outputs are zeroed whenever no column is being presented.
    always_comb begin
        valid_o = emit;
        top_o   = '0;
        mid_o   = '0;
        bot_o   = '0;
        col_o   = '0;
        eol_o   = 1'b0;
        if (emit) begin
            top_o = ram_rd_dat[2*PIX_W-1:PIX_W];
            mid_o = ram_rd_dat[PIX_W-1:0];
            bot_o = pix1_q;
            col_o = col1_q;
            eol_o = (col1_q == COL_LAST);
        end
    end

    // Two-line store, one word per column: {row n-2, row n-1}.
    sync_ram_block #(
        .WIDTH_P (2*PIX_W),
        .DEPTH_P (LINE_W)
    ) u_line_ram (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rd_en_a_i   (accept),
        .rd_addr_a_i (col_eff),
        .rd_dat_a_o  (ram_rd_dat),
        .rd_en_b_i   (1'b0),
        .rd_addr_b_i ('0),
        .rd_dat_b_o  (ram_b_unused),
        .wr_en_i     (retire),
        .wr_addr_i   (col1_q),
        .wr_dat_i    (ram_wr_dat)
    );

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Self-checking bench for sobel_line_buffer (PIX_W=8, LINE_W=4).
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Scoreboard model predicts every emitted column; tables and hand sequences cover corner cases.
module tb_sobel_line_buffer;

    logic       clk_i;
    logic       rstn_i;
    logic [7:0] pix_i;
    logic       sof_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] top_o;
    logic [7:0] mid_o;
    logic [7:0] bot_o;
    logic [1:0] col_o;
    logic       eol_o;
    logic       valid_o;
    logic       ready_i;

    sobel_line_buffer #(.PIX_W(8), .LINE_W(4)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .pix_i   (pix_i),
        .sof_i   (sof_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .top_o   (top_o),
        .mid_o   (mid_o),
        .bot_o   (bot_o),
        .col_o   (col_o),
        .eol_o   (eol_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic [1:0] col;
        logic       eol;
    } exp_t;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       vld;
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic [1:0] col;
        logic       eol;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   fires  = 0;
    bit   rand_mode = 0;
    exp_t q[$];

    // reference model state
    logic [7:0] l1_m [4];
    logic [7:0] l2_m [4];
    int         row_m = 0;
    int         col_m = 0;
    bit         prev_stall = 0;
    logic [7:0] held_top, held_mid, held_bot;
    logic [1:0] held_col;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: compare fired columns, watch stalls, and advance the model on accepts.
    always @(negedge clk_i) begin : monitor
        int   c, r;
        exp_t e;
        if (!rstn_i) begin
            row_m = 0;
            col_m = 0;
            prev_stall = 0;
            q.delete();
        end else begin
            if (prev_stall) chk("valid_held_in_stall", valid_o, 1);
            if (valid_o && ready_i) begin
                fires++;
                if (q.size() == 0) begin
                    chk("unexpected_triple", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_top", top_o, e.top);
                    chk("sb_mid", mid_o, e.mid);
                    chk("sb_bot", bot_o, e.bot);
                    chk("sb_col", col_o, e.col);
                    chk("sb_eol", eol_o, e.eol);
                end
            end
            if (valid_o && !ready_i) begin
                chk("stall_ready_o", ready_o, 0);
                if (prev_stall) begin
                    chk("stall_top_stable", top_o, held_top);
                    chk("stall_mid_stable", mid_o, held_mid);
                    chk("stall_bot_stable", bot_o, held_bot);
                    chk("stall_col_stable", col_o, held_col);
                end
                held_top = top_o;
                held_mid = mid_o;
                held_bot = bot_o;
                held_col = col_o;
            end
            prev_stall = valid_o && !ready_i;
            if (valid_i && ready_o) begin
                c = sof_i ? 0 : col_m;
                r = sof_i ? 0 : row_m;
                if (r == 2) begin
                    e.top = l2_m[c];
                    e.mid = l1_m[c];
                    e.bot = pix_i;
                    e.col = c[1:0];
                    e.eol = (c == 3);
                    q.push_back(e);
                end
                l2_m[c] = l1_m[c];
                l1_m[c] = pix_i;
                if (c == 3) begin
                    col_m = 0;
                    row_m = (r < 2) ? r + 1 : r;
                end else begin
                    col_m = c + 1;
                    row_m = r;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_mode) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) tick();
    endtask

    // Present one pixel and hold it until accepted; n returns the cycles it took.
    task automatic send(input logic [7:0] p, input logic s, output int n);
        logic acc;
        n = 0;
        acc = 1'b0;
        pix_i = p;
        sof_i = s;
        valid_i = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk_i);
            acc = ready_o;
            tick();
            n++;
        end
        valid_i = 1'b0;
        sof_i = 1'b0;
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || valid_o) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[20];

    initial begin : main
        int n, slow, f0;
        int i;

        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                i = r * 4 + c;
                tbl[i].pix = 8'(10 * r + c);
                tbl[i].sof = (i == 0);
                tbl[i].vld = (r >= 2);
                tbl[i].top = (r >= 2) ? 8'(10 * (r - 2) + c) : 8'd0;
                tbl[i].mid = (r >= 2) ? 8'(10 * (r - 1) + c) : 8'd0;
                tbl[i].bot = (r >= 2) ? 8'(10 * r + c) : 8'd0;
                tbl[i].col = 2'(c);
                tbl[i].eol = (r >= 2) && (c == 3);
            end
        end

        // reset state
        rstn_i = 1'b0;
        pix_i = '0;
        sof_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 1);
        chk("rst_col_o", col_o, 0);
        chk("rst_eol_o", eol_o, 0);
        chk("rst_top_o", top_o, 0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            chk("idle_valid_o", valid_o, 0);
            tick();
        end

        // table: priming rows 0-1, then rows 2-4 at full rate
        f0 = fires;
        slow = 0;
        for (int k = 0; k < 20; k++) begin
            send(tbl[k].pix, tbl[k].sof, n);
            if (n != 1) slow++;
            chk("tbl_valid_o", valid_o, tbl[k].vld);
            if (tbl[k].vld) begin
                chk("tbl_top", top_o, tbl[k].top);
                chk("tbl_mid", mid_o, tbl[k].mid);
                chk("tbl_bot", bot_o, tbl[k].bot);
                chk("tbl_col", col_o, tbl[k].col);
                chk("tbl_eol", eol_o, tbl[k].eol);
            end
        end
        tick();
        chk("tbl_slow_sends", slow, 0);
        chk("tbl_triples", fires - f0, 12);

        // backpressure mid row 3
        f0 = fires;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == 3 && c == 2) break;
                send(8'(10 * r + c), (r == 0 && c == 0), n);
            end
        end
        ready_i = 1'b0;
        pix_i = 8'd32;
        valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("bp_valid_o", valid_o, 1);
            chk("bp_top", top_o, 11);
            chk("bp_mid", mid_o, 21);
            chk("bp_bot", bot_o, 31);
            chk("bp_col", col_o, 1);
            chk("bp_ready_o", ready_o, 0);
            tick();
        end
        ready_i = 1'b1;
        send(8'd32, 1'b0, n);
        send(8'd33, 1'b0, n);
        drain();
        chk("bp_triples", fires - f0, 8);

        // sof mid-line at row 3 col 2
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == 3 && c == 2) break;
                send(8'(10 * r + c), (r == 0 && c == 0), n);
            end
        end
        send(8'd100, 1'b1, n);
        f0 = fires;
        for (int k = 1; k < 8; k++) begin
            send(8'(100 + 10 * (k / 4) + (k % 4)), 1'b0, n);
        end
        tick();
        chk("sof_no_output", fires - f0, 0);
        send(8'd120, 1'b0, n);
        chk("sof_valid_o", valid_o, 1);
        chk("sof_top", top_o, 100);
        chk("sof_mid", mid_o, 110);
        chk("sof_bot", bot_o, 120);
        chk("sof_col", col_o, 0);
        drain();

        // random pixels with random valid/ready
        f0 = fires;
        rand_mode = 1;
        for (int k = 0; k < 24; k++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom_range(0, 255)), (k == 0), n);
        end
        drain();
        rand_mode = 0;
        ready_i = 1'b1;
        tick();
        chk("rand_triples", fires - f0, 16);
        chk("end_queue_empty", q.size(), 0);

        if (errors == 0) $display("sobel_line_buffer_tb passed");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (errors != 0) $fatal(1, "sobel_line_buffer_tb detected errors");
        $finish;
    end

endmodule
